sprite_palette_bank: RTL and testbench
======================================

// Module: sprite_palette_bank
// PURPOSE
//  Parametrised, writable multi-bank sprite palette. Replaces fixed per-sprite palette ROMs.
//  Maps a sprite pixel index plus a bank select to 4:4:4 RGB through a registered lookup.
//  Flags transparent pixels. Sits between the sprite ROM readout and the VGA colour mux.
//  Run-time writes recolour enemy variants, e.g. green/red soldiers sharing one sprite sheet.
// PARAMETERS
//  IDX_W      3   pixel index width; each bank holds 2**IDX_W entries
//  NUM_BANKS  4   number of palette banks; BANK_W = $clog2(NUM_BANKS), minimum 1
//  COLOR_W    4   bits per colour channel
//  TRANSP_IDX 0   index reported as transparent
//  FLASH_LEN  8   hit-flash duration in cycles (used only with SPRITE_PAL_FLASH_EN)
// PORTS
//  Clk         in   1           system clock, rising edge
//  Reset_n     in   1           asynchronous, active-low reset
//  pix_valid   in   1           lookup request this cycle
//  bank_sel    in   BANK_W      palette bank for this lookup
//  index       in   IDX_W       sprite pixel index
//  wr_en       in   1           palette write strobe
//  wr_bank     in   BANK_W      bank written
//  wr_idx      in   IDX_W       entry written
//  wr_rgb      in   3*COLOR_W   {r,g,b} write data
//  flash_trig  in   1           one-cycle hit pulse (flash feature)
//  red         out  COLOR_W     looked-up red
//  green       out  COLOR_W     looked-up green
//  blue        out  COLOR_W     looked-up blue
//  out_valid   out  1           red/green/blue/transparent valid
//  transparent out  1           registered (index == TRANSP_IDX)
//  flashing    out  1           flash counter nonzero
// BEHAVIOUR
//  - Reset (Reset_n=0, async): red/green/blue=0, out_valid=0, transparent=0,
//    flashing=0, flash counter=0.
//  - Reset contents: every bank loads the default 8-entry table, in order:
//    997,0E0,060,000,DAA,910,444,EEE. Entries 8 and up reset to 000.
//    The table is defined at COLOR_W=4; for other widths each channel is MSB-aligned.
//  - Lookup latency is 1 cycle. Request in cycle N gives outputs in cycle N+1.
//    out_valid in N+1 = pix_valid in N.
//    When pix_valid=0, colour and transparent outputs hold their last values.
//  - Writes take effect at the clock edge; any bank/entry can be written in any cycle.
//  - Same-entry read and write in one cycle: the read returns the OLD data.
//    The new data is visible from the next cycle.
//  - Bank select out of range (bank_sel >= NUM_BANKS): returns bank 0 contents.
//    An out-of-range write is dropped.
//  - transparent depends on index only, not on bank or stored colour.
//  - Asserting Reset_n mid-frame restores the default table immediately.
//    Writes made before the reset are lost.
// CONFIGURATION
//  SPRITE_PAL_FLASH_EN defined:
//  - flash_trig=1 loads the counter with FLASH_LEN. The counter then decrements each cycle to 0.
//  - A trigger while the counter is nonzero reloads it to FLASH_LEN (retrigger).
//  - flashing is 1 while the counter is nonzero.
//  - While flashing, non-transparent lookups output all-ones on every channel.
//    The override is sampled on the request cycle, together with the lookup.
//  - Transparent pixels are never forced.
//  SPRITE_PAL_FLASH_EN undefined: flash_trig is ignored, flashing is tied to 0,
//  no counter logic is built, and outputs are the plain lookup.
// TESTING
//  - Reset, then lookup bank0 idx1..7 -> 0E0,060,000,DAA,910,444,EEE, one cycle after each request.
//  - idx0 lookup -> rgb 997 with transparent=1; idx3 -> transparent=0.
//  - Write bank2 idx1 = F00, read bank2 idx1 next cycle -> F00; read bank1 idx1 -> 0E0 (unchanged).
//  - Write and read bank0 idx5 = 0F0 in the same cycle -> 910 returned; next read -> 0F0.
//  - Pulse Reset_n low mid-stream (async, between edges) -> outputs 0 at once; bank2 idx1 back to 0E0.
//  - FLASH_EN: flash_trig, then lookups idx2/idx0 -> FFF and 997 with transparent=1.
//    Retrigger at cycle 5 -> flashing held until 8 cycles later.
//    With the macro off, flash_trig gives no output change and flashing=0.

Source files
------------

// File: rtl/sprite_palette_bank.sv
// Multi-bank writable sprite palette: registered index-to-RGB lookup with transparency flag.
// Optional hit-flash override is built only when SPRITE_PAL_FLASH_EN is defined.
module sprite_palette_bank #(
    parameter int IDX_W      = 3,
    parameter int NUM_BANKS  = 4,
    parameter int COLOR_W    = 4,
    parameter int TRANSP_IDX = 0,
    parameter int FLASH_LEN  = 8,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int RGB_W     = 3 * COLOR_W
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               pix_valid,
    input  logic [BANK_W-1:0]  bank_sel,
    input  logic [IDX_W-1:0]   index,
    input  logic               wr_en,
    input  logic [BANK_W-1:0]  wr_bank,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [RGB_W-1:0]   wr_rgb,
    input  logic               flash_trig,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               out_valid,
    output logic               transparent,
    output logic               flashing
);

    localparam int DEPTH = 2 ** IDX_W;

    // Default table is authored as 4-bit nibbles; each channel is MSB-aligned to COLOR_W.
    function automatic logic [RGB_W-1:0] default_entry(input int e);
        logic [11:0]      tbl;
        logic [RGB_W-1:0] v;
        case (e)
            0:       tbl = 12'h997;
            1:       tbl = 12'h0E0;
            2:       tbl = 12'h060;
            3:       tbl = 12'h000;
            4:       tbl = 12'hDAA;
            5:       tbl = 12'h910;
            6:       tbl = 12'h444;
            7:       tbl = 12'hEEE;
            default: tbl = 12'h000;
        endcase
        v = '0;
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < COLOR_W && b < 4; b++) begin
                v[(c + 1) * COLOR_W - 1 - b] = tbl[(c + 1) * 4 - 1 - b];
            end
        end
        return v;
    endfunction

    logic [RGB_W-1:0]  pal [NUM_BANKS][DEPTH];
    logic              rd_bank_ok;
    logic              wr_bank_ok;
    logic [BANK_W-1:0] rd_bank;
    logic              is_transp;
    logic              force_white;

    assign rd_bank_ok = ({1'b0, bank_sel} < (BANK_W + 1)'(NUM_BANKS));
    assign wr_bank_ok = ({1'b0, wr_bank}  < (BANK_W + 1)'(NUM_BANKS));
    assign rd_bank    = rd_bank_ok ? bank_sel : '0;
    assign is_transp  = (index == IDX_W'(TRANSP_IDX));

`ifdef SPRITE_PAL_FLASH_EN
    localparam int CNT_W = $clog2(FLASH_LEN + 1);

    logic [CNT_W-1:0] flash_cnt;

    // Retrigger simply reloads; the count restarts from the full length.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_cnt <= '0;
        end else if (flash_trig) begin
            flash_cnt <= CNT_W'(FLASH_LEN);
        end else if (flash_cnt != '0) begin
            flash_cnt <= flash_cnt - 1'b1;
        end
    end

    assign flashing    = (flash_cnt != '0);
    assign force_white = flashing && !is_transp;
`else
    logic unused_flash;

    assign unused_flash = flash_trig | (FLASH_LEN == 0);
    assign flashing     = 1'b0;
    assign force_white  = 1'b0;
`endif

    // Read uses the pre-edge array contents, so a same-entry write is seen one cycle later.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            out_valid   <= 1'b0;
            transparent <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    pal[b][e] <= default_entry(e);
                end
            end
        end else begin
            out_valid <= pix_valid;
            if (pix_valid) begin
                transparent <= is_transp;
                if (force_white) begin
                    {red, green, blue} <= '1;
                end else begin
                    {red, green, blue} <= pal[rd_bank][index];
                end
            end
            if (wr_en && wr_bank_ok) begin
                pal[wr_bank][wr_idx] <= wr_rgb;
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank: directed steps then random traffic,
// compared against a table-based palette model; honours SPRITE_PAL_FLASH_EN.
module tb_sprite_palette_bank;

    localparam int NB   = 4;
    localparam int FLEN = 8;
`ifdef SPRITE_PAL_FLASH_EN
    localparam bit FLASH_ON = 1'b1;
`else
    localparam bit FLASH_ON = 1'b0;
`endif
    localparam logic [11:0] DEF_TBL [8] = '{12'h997, 12'h0E0, 12'h060, 12'h000,
                                            12'hDAA, 12'h910, 12'h444, 12'hEEE};

    logic        Clk;
    logic        Reset_n;
    logic        pix_valid;
    logic [1:0]  bank_sel;
    logic [2:0]  index;
    logic        wr_en;
    logic [1:0]  wr_bank;
    logic [2:0]  wr_idx;
    logic [11:0] wr_rgb;
    logic        flash_trig;
    logic [3:0]  red, green, blue;
    logic        out_valid, transparent, flashing;

    sprite_palette_bank dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .bank_sel(bank_sel),
        .index(index), .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
        .wr_rgb(wr_rgb), .flash_trig(flash_trig), .red(red), .green(green),
        .blue(blue), .out_valid(out_valid), .transparent(transparent),
        .flashing(flashing)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [11:0] mpal [NB][8];
    logic [11:0] exp_rgb;
    logic        exp_transp;
    logic        exp_valid;
    int          flash_left;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int e = 0; e < 8; e++)
                mpal[b][e] = DEF_TBL[e];
        exp_rgb    = 12'h000;
        exp_transp = 1'b0;
        exp_valid  = 1'b0;
        flash_left = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rgb"},      {red, green, blue}, exp_rgb);
        check({tag, ".transp"},   transparent,        exp_transp);
        check({tag, ".valid"},    out_valid,          exp_valid);
        check({tag, ".flashing"}, flashing,           flash_left > 0);
    endtask

    // One clock: drive, advance the model at the edge, compare just after it.
    task automatic step(input string tag, input logic pv, input logic [1:0] bs,
                        input logic [2:0] ix, input logic we, input logic [1:0] wb,
                        input logic [2:0] wi, input logic [11:0] wd, input logic ft);
        int rb;
        pix_valid  = pv;
        bank_sel   = bs;
        index      = ix;
        wr_en      = we;
        wr_bank    = wb;
        wr_idx     = wi;
        wr_rgb     = wd;
        flash_trig = ft;
        @(posedge Clk);
        rb = (int'(bs) < NB) ? int'(bs) : 0;
        exp_valid = pv;
        if (pv) begin
            exp_transp = (ix == 3'd0);
            exp_rgb    = (flash_left > 0 && ix != 3'd0) ? 12'hFFF : mpal[rb][ix];
        end
        if (we && int'(wb) < NB) mpal[wb][wi] = wd;
        if (FLASH_ON) begin
            if (ft) flash_left = FLEN;
            else if (flash_left > 0) flash_left--;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic rd(input string tag, input logic [1:0] bs, input logic [2:0] ix);
        step(tag, 1'b1, bs, ix, 1'b0, 2'd0, 3'd0, 12'h000, 1'b0);
    endtask

    initial begin
        Reset_n = 1'b0;
        pix_valid = 1'b0; bank_sel = '0; index = '0; wr_en = 1'b0;
        wr_bank = '0; wr_idx = '0; wr_rgb = '0; flash_trig = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        Reset_n = 1'b1;

        for (int i = 1; i < 8; i++) rd("bank0_lookup", 2'd0, 3'(i));
        check("bank0_idx7_const", {red, green, blue}, 12'hEEE);
        rd("idx0_transp", 2'd0, 3'd0);
        check("idx0_const", {red, green, blue, transparent}, {12'h997, 1'b1});
        rd("idx3_opaque", 2'd3, 3'd3);
        step("hold", 1'b0, 2'd1, 3'd4, 1'b0, 2'd0, 3'd0, 12'h000, 1'b0);

        step("wr_b2i1", 1'b0, 2'd0, 3'd0, 1'b1, 2'd2, 3'd1, 12'hF00, 1'b0);
        rd("rd_b2i1", 2'd2, 3'd1);
        check("b2i1_const", {red, green, blue}, 12'hF00);
        rd("rd_b1i1", 2'd1, 3'd1);
        check("b1i1_const", {red, green, blue}, 12'h0E0);

        step("rw_same", 1'b1, 2'd0, 3'd5, 1'b1, 2'd0, 3'd5, 12'h0F0, 1'b0);
        check("rw_old_const", {red, green, blue}, 12'h910);
        rd("rw_next", 2'd0, 3'd5);
        check("rw_new_const", {red, green, blue}, 12'h0F0);

        step("flash_trig", 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 12'h000, 1'b1);
        rd("flash_idx2", 2'd0, 3'd2);
        check("flash_idx2_const", {red, green, blue}, FLASH_ON ? 12'hFFF : 12'h060);
        rd("flash_idx0", 2'd0, 3'd0);
        check("flash_idx0_const", {red, green, blue, transparent}, {12'h997, 1'b1});
        for (int i = 0; i < 10; i++) rd("flash_drain", 2'd1, 3'(i % 8));

        step("retrig0", 1'b0, 2'd0, 3'd0, 1'b0, 2'd0, 3'd0, 12'h000, 1'b1);
        for (int i = 1; i < 5; i++) rd("retrig_wait", 2'd0, 3'(i));
        step("retrig5", 1'b1, 2'd0, 3'd6, 1'b0, 2'd0, 3'd0, 12'h000, 1'b1);
        for (int i = 0; i < 10; i++) rd("retrig_tail", 2'd0, 3'(i % 8));

        for (int i = 0; i < 300; i++) begin
            step("random", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 12'($urandom), 1'($urandom_range(0, 19) == 0));
        end

        step("pre_rst_wr", 1'b1, 2'd2, 3'd1, 1'b1, 2'd2, 3'd1, 12'hF00, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        #2;
        Reset_n = 1'b1;
        rd("post_rst_b2i1", 2'd2, 3'd1);
        check("post_rst_const", {red, green, blue}, 12'h0E0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
